bmd_64_wdma_tlp_seq: RTL and testbench

//  Write-DMA TLP sequencer, directly downstream of the write-DMA control FSM.

---
 rtl/bmd_64_wdma_tlp_seq_pkg.sv | 42 ++++
 rtl/bmd_64_wdma_tlp_seq.sv | 139 +++++++++++++
 tb/tb_bmd_64_wdma_tlp_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bmd_64_wdma_tlp_seq_pkg.sv
// Shared definitions for the write-DMA TLP sequencer.
// Holds the one-hot state encoding, the MPS code constants, the default
// frame size, and the MPS decode helper (code -> bytes/len/need/n_tlp).
package bmd_64_wdma_tlp_seq_pkg;

  localparam int unsigned FRAME_BYTES_DEF  = 2048;
  localparam int unsigned MAX_MPS_CODE_DEF = 2;

  localparam logic [2:0] MPS_128 = 3'd0;
  localparam logic [2:0] MPS_256 = 3'd1;
  localparam logic [2:0] MPS_512 = 3'd2;

  typedef enum logic [6:0] {
    S_IDLE      = 7'b0000001,
    S_WAIT_DATA = 7'b0000010,
    S_ISSUE     = 7'b0000100,
    S_REQ       = 7'b0001000,
    S_XFER      = 7'b0010000,
    S_DONE      = 7'b0100000,
    S_HOLD      = 7'b1000000
  } wdma_state_t;

  typedef struct packed {
    logic [15:0] bytes;    // payload bytes per TLP
    logic [9:0]  len_dw;   // TLP length in DWORDs
    logic [15:0] need_qw;  // FIFO QWORDs required before issuing a TLP
    logic [7:0]  n_tlp;    // TLPs per frame
  } mps_cfg_t;

  function automatic mps_cfg_t mps_decode(input logic [2:0] code,
                                          input int unsigned frame_bytes);
    mps_cfg_t    c;
    int unsigned b;
    b         = 32'd128 << code;
    c.bytes   = 16'(b);
    c.len_dw  = 10'(b / 4);
    c.need_qw = 16'(b / 8);
    c.n_tlp   = 8'(frame_bytes / b);
    return c;
  endfunction

endpackage

// File: rtl/bmd_64_wdma_tlp_seq.sv
// Write-DMA TLP sequencer.
// Accepts one frame request (level start + base address), splits the frame
// into MPS-sized memory-write TLP descriptors for the 64-bit TX engine, gates
// each TLP on frame-FIFO fill level, and pulses done when the frame is sent.
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   init_rst_i            sync soft reset / abort
//   wdma_start_i/addr_i   frame request (level) and base byte address
//   wdma_done_o           1-cycle frame-complete pulse
//   mps_i                 PCIe MPS code, sampled at accept (clamped)
//   fifo_qw_cnt_i         QWORDs available in the frame FIFO
//   tlp_req_o/addr_o/len_dw_o/64b_o   descriptor to TX engine
//   tlp_ack_i, tlp_sent_i descriptor accepted / payload finished
//   align_err_o           sticky misaligned-frame flag
//   tlp_cnt_o             TLPs completed in current frame
module bmd_64_wdma_tlp_seq
  import bmd_64_wdma_tlp_seq_pkg::*;
#(
  parameter int unsigned FRAME_BYTES  = FRAME_BYTES_DEF,
  parameter int unsigned ADDR_W       = 40,
  parameter int unsigned FIFO_CNT_W   = 10,
  parameter int unsigned MAX_MPS_CODE = MAX_MPS_CODE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_rst_i,
  input  logic                  wdma_start_i,
  input  logic [ADDR_W-1:0]     wdma_addr_i,
  output logic                  wdma_done_o,
  input  logic [2:0]            mps_i,
  input  logic [FIFO_CNT_W-1:0] fifo_qw_cnt_i,
  output logic                  tlp_req_o,
  output logic [ADDR_W-1:0]     tlp_addr_o,
  output logic [9:0]            tlp_len_dw_o,
  output logic                  tlp_64b_o,
  input  logic                  tlp_ack_i,
  input  logic                  tlp_sent_i,
  output logic                  align_err_o,
  output logic [7:0]            tlp_cnt_o
);

  localparam int unsigned ALIGN_W = $clog2(FRAME_BYTES);

  wdma_state_t       state;
  mps_cfg_t          cfg;
  mps_cfg_t          mps_dec;
  logic [2:0]        mps_eff;
  logic [ADDR_W-1:0] addr_next;
  logic [15:0]       fifo_cnt_ext;
  logic [7:0]        cnt_next;

  always_comb begin
    mps_eff      = (mps_i > 3'(MAX_MPS_CODE)) ? 3'(MAX_MPS_CODE) : mps_i;
    mps_dec      = mps_decode(mps_eff, FRAME_BYTES);
    addr_next    = tlp_addr_o + ADDR_W'(cfg.bytes);
    fifo_cnt_ext = 16'(fifo_qw_cnt_i);
    cnt_next     = tlp_cnt_o + 8'd1;
  end

  // ISSUE is a one-cycle stage so that the registered req rises the cycle
  // after the FIFO threshold is met, keeping addr/len/64b stable under req.
  // done is set on the transition into DONE so it is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cfg          <= '0;
      wdma_done_o  <= 1'b0;
      tlp_req_o    <= 1'b0;
      tlp_addr_o   <= '0;
      tlp_len_dw_o <= '0;
      tlp_64b_o    <= 1'b0;
      align_err_o  <= 1'b0;
      tlp_cnt_o    <= '0;
    end else if (init_rst_i) begin
      state        <= S_IDLE;
      cfg          <= '0;
      wdma_done_o  <= 1'b0;
      tlp_req_o    <= 1'b0;
      tlp_addr_o   <= '0;
      tlp_len_dw_o <= '0;
      tlp_64b_o    <= 1'b0;
      align_err_o  <= 1'b0;
      tlp_cnt_o    <= '0;
    end else begin
      wdma_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wdma_start_i) begin
            cfg <= mps_dec;
            if (wdma_addr_i[ALIGN_W-1:0] != '0) begin
              align_err_o <= 1'b1;
              wdma_done_o <= 1'b1;
              state       <= S_DONE;
            end else begin
              tlp_addr_o <= wdma_addr_i;
              tlp_64b_o  <= |wdma_addr_i[ADDR_W-1:32];
              tlp_cnt_o  <= '0;
              state      <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          if (fifo_cnt_ext >= cfg.need_qw) state <= S_ISSUE;
        end
        S_ISSUE: begin
          tlp_req_o    <= 1'b1;
          tlp_len_dw_o <= cfg.len_dw;
          state        <= S_REQ;
        end
        S_REQ: begin
          // a sent coinciding with ack is ignored here; only XFER consumes it
          if (tlp_ack_i) begin
            tlp_req_o <= 1'b0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (tlp_sent_i) begin
            tlp_cnt_o  <= cnt_next;
            tlp_addr_o <= addr_next;
            tlp_64b_o  <= |addr_next[ADDR_W-1:32];
            if (cnt_next == cfg.n_tlp) begin
              wdma_done_o <= 1'b1;
              state       <= S_DONE;
            end else begin
              state <= S_WAIT_DATA;
            end
          end
        end
        S_DONE: state <= S_HOLD;
        S_HOLD: begin
          if (!wdma_start_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmd_64_wdma_tlp_seq.sv
// Directed testbench for bmd_64_wdma_tlp_seq.
module tb_bmd_64_wdma_tlp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_rst_i;
  logic        wdma_start_i;
  logic [39:0] wdma_addr_i;
  logic        wdma_done_o;
  logic [2:0]  mps_i;
  logic [9:0]  fifo_qw_cnt_i;
  logic        tlp_req_o;
  logic [39:0] tlp_addr_o;
  logic [9:0]  tlp_len_dw_o;
  logic        tlp_64b_o;
  logic        tlp_ack_i;
  logic        tlp_sent_i;
  logic        align_err_o;
  logic [7:0]  tlp_cnt_o;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  bmd_64_wdma_tlp_seq #(
    .FRAME_BYTES(2048),
    .ADDR_W(40),
    .FIFO_CNT_W(10),
    .MAX_MPS_CODE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_rst_i(init_rst_i),
    .wdma_start_i(wdma_start_i),
    .wdma_addr_i(wdma_addr_i),
    .wdma_done_o(wdma_done_o),
    .mps_i(mps_i),
    .fifo_qw_cnt_i(fifo_qw_cnt_i),
    .tlp_req_o(tlp_req_o),
    .tlp_addr_o(tlp_addr_o),
    .tlp_len_dw_o(tlp_len_dw_o),
    .tlp_64b_o(tlp_64b_o),
    .tlp_ack_i(tlp_ack_i),
    .tlp_sent_i(tlp_sent_i),
    .align_err_o(align_err_o),
    .tlp_cnt_o(tlp_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Service one TLP: wait (bounded) for req, check the descriptor, ack, send.
  task automatic do_tlp(input string tag, input logic [39:0] exp_addr,
                        input logic [9:0] exp_len, input logic exp64);
    int k;
    k = 0;
    while (!tlp_req_o && k < 20) begin
      tick();
      k++;
    end
    chk($sformatf("%s req", tag), tlp_req_o, 1);
    chk($sformatf("%s addr", tag), tlp_addr_o, exp_addr);
    chk($sformatf("%s len", tag), tlp_len_dw_o, exp_len);
    chk($sformatf("%s 64b", tag), tlp_64b_o, exp64);
    tlp_ack_i = 1'b1;
    tick();
    tlp_ack_i = 1'b0;
    chk($sformatf("%s req_drop", tag), tlp_req_o, 0);
    tlp_sent_i = 1'b1;
    tick();
    tlp_sent_i = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] exp_cnt,
                              input logic [39:0] exp_addr, input logic exp64);
    chk($sformatf("%s done", tag), wdma_done_o, 1);
    chk($sformatf("%s cnt", tag), tlp_cnt_o, exp_cnt);
    chk($sformatf("%s end_addr", tag), tlp_addr_o, exp_addr);
    chk($sformatf("%s end_64b", tag), tlp_64b_o, exp64);
    wdma_start_i = 1'b0;
    tick();
    chk($sformatf("%s done_pulse", tag), wdma_done_o, 0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic seen_req;
    logic seen_done;
    logic [39:0] a;

    rst_n = 1'b0;
    init_rst_i = 1'b0;
    wdma_start_i = 1'b0;
    wdma_addr_i = '0;
    mps_i = 3'd0;
    fifo_qw_cnt_i = 10'h3FF;
    tlp_ack_i = 1'b0;
    tlp_sent_i = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst done", wdma_done_o, 0);
    chk("rst req", tlp_req_o, 0);
    chk("rst addr", tlp_addr_o, 0);
    chk("rst len", tlp_len_dw_o, 0);
    chk("rst 64b", tlp_64b_o, 0);
    chk("rst align", align_err_o, 0);
    chk("rst cnt", tlp_cnt_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: 128 B MPS, 16 TLPs of 32 DW stepping 0x80
    mps_i = 3'd0;
    wdma_addr_i = 40'h00_1000_0000;
    wdma_start_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 40'h00_1000_0000 + 40'(i * 128);
      do_tlp($sformatf("t1.%0d", i), a, 10'd32, 1'b0);
    end
    finish_frame("t1", 8'd16, 40'h00_1000_0800, 1'b0);

    // 2: 512 B MPS, 4DW header
    mps_i = 3'd2;
    wdma_addr_i = 40'hA5_0000_0800;
    wdma_start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 40'hA5_0000_0800 + 40'(i * 512);
      do_tlp($sformatf("t2.%0d", i), a, 10'd128, 1'b1);
    end
    finish_frame("t2", 8'd4, 40'hA5_0000_1000, 1'b1);

    // 3: FIFO one QWORD short of the 512 B need holds off req
    mps_i = 3'd2;
    fifo_qw_cnt_i = 10'd63;
    wdma_addr_i = 40'h00_0001_0000;
    wdma_start_i = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tlp_req_o) seen_req = 1'b1;
    end
    chk("t3 no_req_at_63", seen_req, 0);
    fifo_qw_cnt_i = 10'd64;
    tick();
    chk("t3 req_lat1", tlp_req_o, 0);
    tick();
    chk("t3 req_lat2", tlp_req_o, 1);
    for (int i = 0; i < 4; i++) begin
      a = 40'h00_0001_0000 + 40'(i * 512);
      do_tlp($sformatf("t3.%0d", i), a, 10'd128, 1'b0);
    end
    finish_frame("t3", 8'd4, 40'h00_0001_0800, 1'b0);
    fifo_qw_cnt_i = 10'h3FF;

    // 6: MPS code 5 clamps to 512 B; address wraps at the top of the space
    mps_i = 3'd5;
    wdma_addr_i = 40'hFF_FFFF_F800;
    wdma_start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 40'hFF_FFFF_F800 + 40'(i * 512);
      do_tlp($sformatf("t6.%0d", i), a, 10'd128, 1'b1);
    end
    finish_frame("t6", 8'd4, 40'h00_0000_0000, 1'b0);

    // 4: misaligned base -> align error, single done, no TLPs
    mps_i = 3'd0;
    wdma_addr_i = 40'h00_0000_0404;
    wdma_start_i = 1'b1;
    tick();
    chk("t4 done", wdma_done_o, 1);
    chk("t4 align", align_err_o, 1);
    chk("t4 req", tlp_req_o, 0);
    chk("t4 cnt_hold", tlp_cnt_o, 4);
    seen_req = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tlp_req_o) seen_req = 1'b1;
      if (wdma_done_o) seen_done = 1'b1;
    end
    chk("t4 no_second_done", seen_done, 0);
    chk("t4 no_req", seen_req, 0);
    chk("t4 align_sticky", align_err_o, 1);
    wdma_start_i = 1'b0;
    tick();
    tick();

    // 5: abort after TLP 3 of 16, then a clean 256 B frame
    mps_i = 3'd0;
    wdma_addr_i = 40'h00_0000_2000;
    wdma_start_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 40'h00_0000_2000 + 40'(i * 128);
      do_tlp($sformatf("t5.%0d", i), a, 10'd32, 1'b0);
    end
    for (int k = 0; k < 20 && !tlp_req_o; k++) tick();
    chk("t5 req4", tlp_req_o, 1);
    chk("t5 addr4", tlp_addr_o, 40'h00_0000_2180);
    init_rst_i = 1'b1;
    wdma_start_i = 1'b0;
    tick();
    init_rst_i = 1'b0;
    chk("t5 abort_req", tlp_req_o, 0);
    chk("t5 abort_cnt", tlp_cnt_o, 0);
    chk("t5 abort_addr", tlp_addr_o, 0);
    chk("t5 abort_align", align_err_o, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wdma_done_o) seen_done = 1'b1;
      tick();
    end
    chk("t5 no_done", seen_done, 0);
    mps_i = 3'd1;
    wdma_addr_i = 40'h00_0000_4000;
    wdma_start_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 40'h00_0000_4000 + 40'(i * 256);
      do_tlp($sformatf("t5b.%0d", i), a, 10'd64, 1'b0);
    end
    finish_frame("t5b", 8'd8, 40'h00_0000_4800, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
